stack_ctrl_fsm: RTL and testbench
=================================

Name: stack_ctrl_fsm

Overview:
Parametrised multicycle control FSM for the stack processor datapath. It sequences fetch, decode and execute, and drives the same datapath control bundle as the current single-cycle-memory controller. It adds three things that controller does not have: a memory ready/wait handshake, a level interrupt with enable flag, and HALT/EI/DI/illegal-opcode handling. It sits between the instruction register opcode and the datapath/memory.

Parameters:
OP_W, 8, opcode width; any bit above [7:0] set makes the opcode illegal.
ALU_OP_W, 4, alu_op width; zero-extended from opcode[3:0].
MEM_HANDSHAKE, 1, 1 = honour mem_ready; 0 = mem_ready treated as constant 1.
IRQ_EN, 1, 0 = irq ignored, ie_flag held at 0.

Ports:
CLK  in  1  clock, rising edge
reset  in  1  synchronous, active-high
opcode  in  OP_W  instruction register contents
mem_ready  in  1  memory completes access this cycle
irq  in  1  level interrupt request
mem_req  out  1  memory access active this state
mem_addr  out  2  00 PC, 01 DP, 10 RP, 11 TR
mem_data  out  1  write-data select: 0 PC+1, 1 TR
mem_write  out  1  memory write
dp_inc, rp_inc  out  2 each  00 hold, 01 +1, 10 −1
reg_write, ir_write, tr_write, pc_write, b_write, out_write, jump, jump_cond, alu_src  out  1 each  datapath enables/selects
tr_src, b_src  out  3 each  source selects
pc_src  out  2  00 PC+1, 01 B, 10 TR, 11 interrupt vector
alu_op  out  ALU_OP_W  ALU function
rst  out  1  datapath reset
irq_ack  out  1  one-cycle pulse on vector load
halted  out  1  high in HALT
illegal  out  1  sticky illegal-opcode flag

Behaviour:
- Output decode is combinational from state and opcode. Defaults are all 0, except b_write=1 and next=FETCH.
- Synchronous reset: on reset=1 at a CLK edge, state←RST, ie_flag←0, illegal←0. In RST: rst=1, all other outputs at default. Next state is FETCH.
- FETCH: if IRQ_EN & ie_flag & irq, go to IRQ_PUSH without touching PC. Otherwise mem_req=1, mem_addr=00, ir_write=1, pc_write=1, pc_src=00, then go to DECODE.
- Wait rule: in any state with mem_req=1, while mem_ready=0 the state holds. mem_req, mem_addr, mem_data and mem_write stay asserted. Every other write enable (ir/pc/tr/reg/out_write, dp_inc, rp_inc, jump) is forced to 0. b_write stays at its state value. Each access takes 1 + N cycles for N wait cycles.
- DECODE: b_src=000. Transitions:
  - 0x00 → FETCH.
  - op[7:4]=0 → ALU.
  - op[7:4] in C/D/E → JMP1.
  - op[7:4]=F or 0x13 → CT.
  - 0x11 LD1, 0x12 ST1, 0x14 FR1, 0x21 BURN, 0x24 SWAP, 0x25 OUT, 0x31 JA.
  - 0x22/0x23/0x80/0x81/0x26 → PUSH1.
  - 0x8A–0x8C → SH1.
  - 0x27 EI, 0x28 DI (set/clear ie_flag, then FETCH).
  - 0x2F → HALT.
  - Anything else: illegal←1, then FETCH.
- Execute states (only non-default outputs listed):
  - ALU: dp_inc=10, alu_src=1, alu_op=op[3:0], tr_src=001, tr_write.
  - BURN: dp_inc=10, tr_write.
  - SWAP: tr_write, reg_write.
  - PUSH1: dp_inc=01, b_write=0. Then PUSH2: reg_write, plus tr_write with tr_src 000 (over), 011 (push), 010 (pushu), 101 (in); dup has reg_write only.
  - LD1: mem_req, addr 11, b_src=001. Then LD2: tr_write.
  - ST1: dp_inc=10, b_write=0. Then ST2: mem_req, mem_write, addr 01, mem_data=1, tr_src=100, tr_write, dp_inc=10.
  - FR1: mem_req, addr 10, b_src=001, rp_inc=01, dp_inc=01. Then FR2: reg_write, tr_write.
  - JA: pc_write, pc_src=10, tr_write, dp_inc=10.
  - SH1: b_src=011. Then SH2: tr_src=001, tr_write, alu_src=1, alu_op=op[3:0].
  - JMP1: b_src=100. Then JMP2: alu_op=1. Then:
    - C/D: jump=1, jump_cond=1 (C) or 0 (D), pc_src=01, dp_inc=10, alu_src=1, alu_op=2; then JPOP: tr_src=100, tr_write, dp_inc=10.
    - E: go to JC.
  - CT: rp_inc=10, b_src=100, then CALL (F) or TOR (0x13).
    - CALL: mem_req, mem_write, addr 10, mem_data=0, alu_op=1; then JC.
    - TOR: mem_req, mem_write, addr 10, mem_data=1, tr_src=100, tr_write, dp_inc=10.
  - JC: pc_src=01, pc_write.
  - OUT: out_write, tr_write, tr_src=100, dp_inc=10.
  - All execute states end in FETCH.
- Interrupt:
  - IRQ_PUSH: rp_inc=10. Then IRQ_SAVE: mem_req, mem_write, addr 10, mem_data=0 (PC+1 path supplies the current PC).
  - Then IRQ_VEC: pc_src=11, pc_write, irq_ack=1, ie_flag←0, then FETCH.
  - irq is sampled only in FETCH and HALT. Deasserting irq mid-entry does not abort the entry.
- HALT: halted=1. Holds until IRQ_EN & ie_flag & irq, then goes to IRQ_PUSH. Reset also exits.
- Unused state encodings go to RST.
- Reset dominates any state, including a wait hold.

Test Plan:
- Reset held 2 cycles mid-LD2 → next state RST with rst=1 and all enables 0; FETCH follows; illegal=0, ie_flag=0.
- Opcode 0x01, mem_ready=1 → FETCH, DECODE, ALU: alu_op=1, tr_src=001, dp_inc=10; back in FETCH on cycle 4.
- Opcode 0x11 with mem_ready low for 3 cycles in LD1 → LD1 held 4 cycles with mem_req=1, addr=11, no enables; LD2 tr_write once.
- 0x27 then irq=1 at FETCH → IRQ_PUSH, IRQ_SAVE, IRQ_VEC; irq_ack high exactly 1 cycle; pc_src=11; then ie_flag=0 and a second irq is ignored.
- 0x2F with ie_flag=0 → halted stays 1 for 20 cycles with irq=1; reset exits.
- Opcode 0x55 → illegal=1, stays set through 0x01, cleared only by reset.

Source files
------------

// File: rtl/stack_ctrl_fsm.sv
// Multicycle fetch/decode/execute controller for the stack datapath, with a
// memory wait handshake, level interrupt entry, EI/DI, HALT and illegal-opcode trapping.
module stack_ctrl_fsm #(
  parameter int OP_W          = 8,
  parameter int ALU_OP_W      = 4,
  parameter int MEM_HANDSHAKE = 1,
  parameter int IRQ_EN        = 1
) (
  input  logic                CLK,
  input  logic                reset,
  input  logic [OP_W-1:0]     opcode,
  input  logic                mem_ready,
  input  logic                irq,
  output logic                mem_req,
  output logic [1:0]          mem_addr,
  output logic                mem_data,
  output logic                mem_write,
  output logic [1:0]          dp_inc,
  output logic [1:0]          rp_inc,
  output logic                reg_write,
  output logic                ir_write,
  output logic                tr_write,
  output logic                pc_write,
  output logic                b_write,
  output logic                out_write,
  output logic                jump,
  output logic                jump_cond,
  output logic                alu_src,
  output logic [2:0]          tr_src,
  output logic [2:0]          b_src,
  output logic [1:0]          pc_src,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                rst,
  output logic                irq_ack,
  output logic                halted,
  output logic                illegal,
  output logic [5:0]          dbg_state,
  output logic                ie_flag
);

  localparam logic [5:0] S_RST      = 6'd0,  S_FETCH    = 6'd1,  S_DECODE   = 6'd2,
                         S_ALU      = 6'd3,  S_BURN     = 6'd4,  S_SWAP     = 6'd5,
                         S_PUSH1    = 6'd6,  S_PUSH2    = 6'd7,  S_LD1      = 6'd8,
                         S_LD2      = 6'd9,  S_ST1      = 6'd10, S_ST2      = 6'd11,
                         S_FR1      = 6'd12, S_FR2      = 6'd13, S_JA       = 6'd14,
                         S_SH1      = 6'd15, S_SH2      = 6'd16, S_JMP1     = 6'd17,
                         S_JMP2     = 6'd18, S_JCOND    = 6'd19, S_JPOP     = 6'd20,
                         S_CT       = 6'd21, S_CALL     = 6'd22, S_TOR      = 6'd23,
                         S_JC       = 6'd24, S_OUT      = 6'd25, S_IRQ_PUSH = 6'd26,
                         S_IRQ_SAVE = 6'd27, S_IRQ_VEC  = 6'd28, S_HALT     = 6'd29,
                         S_EI       = 6'd30, S_DI       = 6'd31;

  logic [5:0] state, next_state;
  logic       ie_set, ie_clr, ill_set;
  logic [7:0] op8;
  logic [3:0] op_hi, op_lo;
  logic       op_wide, ready, irq_take;

  assign op8       = opcode[7:0];
  assign op_hi     = op8[7:4];
  assign op_lo     = op8[3:0];
  assign op_wide   = (opcode >> 8) != '0;
  assign ready     = (MEM_HANDSHAKE == 0) || mem_ready;
  assign irq_take  = (IRQ_EN != 0) && ie_flag && irq;
  assign dbg_state = state;

  // Memory handshake: an access is offered while mem_req=1 and completes on the
  // first cycle with mem_ready=1; until then address, data select and write hold.
  always_comb begin
    mem_req = 1'b0;  mem_addr = 2'b00; mem_data = 1'b0; mem_write = 1'b0;
    dp_inc = 2'b00;  rp_inc = 2'b00;   reg_write = 1'b0; ir_write = 1'b0;
    tr_write = 1'b0; pc_write = 1'b0;  b_write = 1'b1;   out_write = 1'b0;
    jump = 1'b0;     jump_cond = 1'b0; alu_src = 1'b0;   tr_src = 3'b000;
    b_src = 3'b000;  pc_src = 2'b00;   alu_op = '0;      rst = 1'b0;
    irq_ack = 1'b0;  halted = 1'b0;
    ie_set = 1'b0;   ie_clr = 1'b0;    ill_set = 1'b0;
    next_state = S_FETCH;
    case (state)
      S_RST: rst = 1'b1;
      S_FETCH: begin
        if (irq_take) begin
          next_state = S_IRQ_PUSH;
        end else begin
          mem_req = 1'b1; ir_write = 1'b1; pc_write = 1'b1;
          next_state = S_DECODE;
        end
      end
      S_DECODE: begin
        if (op_wide) ill_set = 1'b1;
        else if (op8 == 8'h00) next_state = S_FETCH;
        else if (op_hi == 4'h0) next_state = S_ALU;
        else if (op_hi == 4'hC || op_hi == 4'hD || op_hi == 4'hE) next_state = S_JMP1;
        else if (op_hi == 4'hF || op8 == 8'h13) next_state = S_CT;
        else begin
          case (op8)
            8'h11: next_state = S_LD1;
            8'h12: next_state = S_ST1;
            8'h14: next_state = S_FR1;
            8'h21: next_state = S_BURN;
            8'h24: next_state = S_SWAP;
            8'h25: next_state = S_OUT;
            8'h31: next_state = S_JA;
            8'h22, 8'h23, 8'h80, 8'h81, 8'h26: next_state = S_PUSH1;
            8'h8A, 8'h8B, 8'h8C: next_state = S_SH1;
            8'h27: next_state = S_EI;
            8'h28: next_state = S_DI;
            8'h2F: next_state = S_HALT;
            default: ill_set = 1'b1;
          endcase
        end
      end
      S_ALU: begin
        dp_inc = 2'b10; alu_src = 1'b1; alu_op = ALU_OP_W'(op_lo);
        tr_src = 3'b001; tr_write = 1'b1;
      end
      S_BURN: begin dp_inc = 2'b10; tr_write = 1'b1; end
      S_SWAP: begin tr_write = 1'b1; reg_write = 1'b1; end
      S_PUSH1: begin dp_inc = 2'b01; b_write = 1'b0; next_state = S_PUSH2; end
      S_PUSH2: begin
        reg_write = 1'b1;
        case (op8)
          8'h23: begin tr_write = 1'b1; tr_src = 3'b000; end
          8'h80: begin tr_write = 1'b1; tr_src = 3'b011; end
          8'h81: begin tr_write = 1'b1; tr_src = 3'b010; end
          8'h26: begin tr_write = 1'b1; tr_src = 3'b101; end
          default: ;
        endcase
      end
      S_LD1: begin mem_req = 1'b1; mem_addr = 2'b11; b_src = 3'b001; next_state = S_LD2; end
      S_LD2: tr_write = 1'b1;
      S_ST1: begin dp_inc = 2'b10; b_write = 1'b0; next_state = S_ST2; end
      S_ST2: begin
        mem_req = 1'b1; mem_write = 1'b1; mem_addr = 2'b01; mem_data = 1'b1;
        tr_src = 3'b100; tr_write = 1'b1; dp_inc = 2'b10;
      end
      S_FR1: begin
        mem_req = 1'b1; mem_addr = 2'b10; b_src = 3'b001; rp_inc = 2'b01; dp_inc = 2'b01;
        next_state = S_FR2;
      end
      S_FR2: begin reg_write = 1'b1; tr_write = 1'b1; end
      S_JA: begin pc_write = 1'b1; pc_src = 2'b10; tr_write = 1'b1; dp_inc = 2'b10; end
      S_SH1: begin b_src = 3'b011; next_state = S_SH2; end
      S_SH2: begin
        tr_src = 3'b001; tr_write = 1'b1; alu_src = 1'b1; alu_op = ALU_OP_W'(op_lo);
      end
      S_JMP1: begin b_src = 3'b100; next_state = S_JMP2; end
      S_JMP2: begin
        alu_op = ALU_OP_W'(4'd1);
        next_state = (op_hi == 4'hE) ? S_JC : S_JCOND;
      end
      S_JCOND: begin
        jump = 1'b1; jump_cond = (op_hi == 4'hC); pc_src = 2'b01; dp_inc = 2'b10;
        alu_src = 1'b1; alu_op = ALU_OP_W'(4'd2); next_state = S_JPOP;
      end
      S_JPOP: begin tr_src = 3'b100; tr_write = 1'b1; dp_inc = 2'b10; end
      S_CT: begin
        rp_inc = 2'b10; b_src = 3'b100;
        next_state = (op_hi == 4'hF) ? S_CALL : S_TOR;
      end
      S_CALL: begin
        mem_req = 1'b1; mem_write = 1'b1; mem_addr = 2'b10; alu_op = ALU_OP_W'(4'd1);
        next_state = S_JC;
      end
      S_TOR: begin
        mem_req = 1'b1; mem_write = 1'b1; mem_addr = 2'b10; mem_data = 1'b1;
        tr_src = 3'b100; tr_write = 1'b1; dp_inc = 2'b10;
      end
      S_JC: begin pc_src = 2'b01; pc_write = 1'b1; end
      S_OUT: begin out_write = 1'b1; tr_write = 1'b1; tr_src = 3'b100; dp_inc = 2'b10; end
      S_IRQ_PUSH: begin rp_inc = 2'b10; next_state = S_IRQ_SAVE; end
      // mem_data=0 stores PC+1 path; PC was not advanced, so this is the resume address.
      S_IRQ_SAVE: begin
        mem_req = 1'b1; mem_write = 1'b1; mem_addr = 2'b10; next_state = S_IRQ_VEC;
      end
      S_IRQ_VEC: begin pc_src = 2'b11; pc_write = 1'b1; irq_ack = 1'b1; ie_clr = 1'b1; end
      S_HALT: begin halted = 1'b1; next_state = irq_take ? S_IRQ_PUSH : S_HALT; end
      S_EI: ie_set = 1'b1;
      S_DI: ie_clr = 1'b1;
      default: next_state = S_RST;
    endcase

    if (mem_req && !ready) begin
      next_state = state;
      ir_write = 1'b0; pc_write = 1'b0; tr_write = 1'b0; reg_write = 1'b0;
      out_write = 1'b0; dp_inc = 2'b00; rp_inc = 2'b00; jump = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state   <= S_RST;
      ie_flag <= 1'b0;
      illegal <= 1'b0;
    end else begin
      state <= next_state;
      if (ill_set) illegal <= 1'b1;
      if (IRQ_EN == 0) ie_flag <= 1'b0;
      else if (ie_set) ie_flag <= 1'b1;
      else if (ie_clr) ie_flag <= 1'b0;
    end
  end

endmodule

// File: tb/tb_stack_ctrl_fsm.sv
// Cycle-accurate scoreboard bench: a per-instruction reference model queues the
// expected control bundle for every cycle; a negedge monitor compares it with the DUT.
module tb_stack_ctrl_fsm;

  typedef struct packed {
    logic       mem_req;
    logic [1:0] mem_addr;
    logic       mem_data;
    logic       mem_write;
    logic [1:0] dp_inc;
    logic [1:0] rp_inc;
    logic       reg_write, ir_write, tr_write, pc_write, b_write, out_write;
    logic       jump, jump_cond, alu_src;
    logic [2:0] tr_src;
    logic [2:0] b_src;
    logic [1:0] pc_src;
    logic [3:0] alu_op;
    logic       rst, irq_ack, halted, illegal, ie;
  } ctl_t;

  localparam int W = $bits(ctl_t);

  logic       clk;
  logic       reset, mem_ready, irq;
  logic [7:0] opcode;
  logic       mem_req, mem_data, mem_write, reg_write, ir_write, tr_write, pc_write;
  logic       b_write, out_write, jump, jump_cond, alu_src, rst, irq_ack, halted, illegal;
  logic       ie_flag;
  logic [1:0] mem_addr, dp_inc, rp_inc, pc_src;
  logic [2:0] tr_src, b_src;
  logic [3:0] alu_op;
  logic [5:0] dbg_state;

  logic [W-1:0] exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc_n = 0;
  bit   m_ie, m_ill;
  int   g_wmax;

  stack_ctrl_fsm dut (
    .CLK(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready), .irq(irq),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_data(mem_data), .mem_write(mem_write),
    .dp_inc(dp_inc), .rp_inc(rp_inc), .reg_write(reg_write), .ir_write(ir_write),
    .tr_write(tr_write), .pc_write(pc_write), .b_write(b_write), .out_write(out_write),
    .jump(jump), .jump_cond(jump_cond), .alu_src(alu_src), .tr_src(tr_src), .b_src(b_src),
    .pc_src(pc_src), .alu_op(alu_op), .rst(rst), .irq_ack(irq_ack), .halted(halted),
    .illegal(illegal), .dbg_state(dbg_state), .ie_flag(ie_flag)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // monitor
  always @(negedge clk) begin
    ctl_t a, e;
    cyc_n++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = '{mem_req, mem_addr, mem_data, mem_write, dp_inc, rp_inc, reg_write, ir_write,
            tr_write, pc_write, b_write, out_write, jump, jump_cond, alu_src, tr_src,
            b_src, pc_src, alu_op, rst, irq_ack, halted, illegal, ie_flag};
      n_vec++;
      if (a !== e) begin
        n_err++;
        $display("FAIL ctl_bundle cycle %0d op=%h: got %h required %h", cyc_n, opcode, a, e);
      end
    end
  end

  // reference model helpers
  function automatic ctl_t dflt();
    ctl_t c = '0;
    c.b_write = 1'b1;
    c.illegal = m_ill;
    c.ie      = m_ie;
    return c;
  endfunction

  function automatic ctl_t mask(input ctl_t c);
    ctl_t m = c;
    m.ir_write = 0; m.pc_write = 0; m.tr_write = 0; m.reg_write = 0;
    m.out_write = 0; m.dp_inc = 0; m.rp_inc = 0; m.jump = 0;
    return m;
  endfunction

  function automatic int rw();
    return (g_wmax == 0) ? 0 : int'($urandom_range(0, g_wmax));
  endfunction

  function automatic bit is_legal(input logic [7:0] op);
    case (op)
      8'h00, 8'h11, 8'h12, 8'h13, 8'h14, 8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26,
      8'h27, 8'h28, 8'h2F, 8'h31, 8'h80, 8'h81, 8'h8A, 8'h8B, 8'h8C: return 1'b1;
      default: return (op[7:4] == 4'h0) || (op[7:4] >= 4'hC);
    endcase
  endfunction

  // driver tasks
  task automatic cyc(input ctl_t c, input logic rdy, input logic rs);
    mem_ready = rdy;
    reset     = rs;
    exp_q.push_back(c);
    @(posedge clk);
    #1;
  endtask

  task automatic step(input ctl_t c);
    cyc(c, 1'($urandom_range(0, 1)), 1'b0);
  endtask

  task automatic mstep(input ctl_t c, input int waits);
    repeat (waits) cyc(mask(c), 1'b0, 1'b0);
    cyc(c, 1'b1, 1'b0);
  endtask

  task automatic reset_tail(input bit held_two);
    ctl_t c;
    m_ill = 0;
    m_ie  = 0;
    c = dflt();
    c.rst = 1;
    if (held_two) cyc(c, 1'($urandom_range(0, 1)), 1'b1);
    cyc(c, 1'($urandom_range(0, 1)), 1'b0);
  endtask

  task automatic irq_tail();
    ctl_t c;
    c = dflt(); c.rp_inc = 2'b10; step(c);
    c = dflt(); c.mem_req = 1; c.mem_write = 1; c.mem_addr = 2'b10; mstep(c, rw());
    c = dflt(); c.pc_src = 2'b11; c.pc_write = 1; c.irq_ack = 1; step(c);
    m_ie = 0;
  endtask

  task automatic fetch_decode(input logic [7:0] op);
    ctl_t c;
    opcode = op;
    if (m_ie && irq) begin
      step(dflt());
      irq_tail();
    end
    c = dflt(); c.mem_req = 1; c.ir_write = 1; c.pc_write = 1; mstep(c, rw());
    step(dflt());
    if (!is_legal(op)) m_ill = 1;
  endtask

  task automatic exec(input logic [7:0] op);
    ctl_t c;
    if (op == 8'h00 || !is_legal(op) || op == 8'h2F) begin
      // nothing beyond decode
    end else if (op[7:4] == 4'h0) begin
      c = dflt(); c.dp_inc = 2'b10; c.alu_src = 1; c.alu_op = op[3:0];
      c.tr_src = 3'b001; c.tr_write = 1; step(c);
    end else if (op[7:4] >= 4'hC && op[7:4] <= 4'hE) begin
      c = dflt(); c.b_src = 3'b100; step(c);
      c = dflt(); c.alu_op = 4'd1; step(c);
      if (op[7:4] == 4'hE) begin
        c = dflt(); c.pc_src = 2'b01; c.pc_write = 1; step(c);
      end else begin
        c = dflt(); c.jump = 1; c.jump_cond = (op[7:4] == 4'hC); c.pc_src = 2'b01;
        c.dp_inc = 2'b10; c.alu_src = 1; c.alu_op = 4'd2; step(c);
        c = dflt(); c.tr_src = 3'b100; c.tr_write = 1; c.dp_inc = 2'b10; step(c);
      end
    end else if (op[7:4] == 4'hF || op == 8'h13) begin
      c = dflt(); c.rp_inc = 2'b10; c.b_src = 3'b100; step(c);
      c = dflt(); c.mem_req = 1; c.mem_write = 1; c.mem_addr = 2'b10;
      if (op == 8'h13) begin
        c.mem_data = 1; c.tr_src = 3'b100; c.tr_write = 1; c.dp_inc = 2'b10;
        mstep(c, rw());
      end else begin
        c.alu_op = 4'd1; mstep(c, rw());
        c = dflt(); c.pc_src = 2'b01; c.pc_write = 1; step(c);
      end
    end else begin
      case (op)
        8'h11: begin
          c = dflt(); c.mem_req = 1; c.mem_addr = 2'b11; c.b_src = 3'b001; mstep(c, rw());
          c = dflt(); c.tr_write = 1; step(c);
        end
        8'h12: begin
          c = dflt(); c.dp_inc = 2'b10; c.b_write = 0; step(c);
          c = dflt(); c.mem_req = 1; c.mem_write = 1; c.mem_addr = 2'b01; c.mem_data = 1;
          c.tr_src = 3'b100; c.tr_write = 1; c.dp_inc = 2'b10; mstep(c, rw());
        end
        8'h14: begin
          c = dflt(); c.mem_req = 1; c.mem_addr = 2'b10; c.b_src = 3'b001;
          c.rp_inc = 2'b01; c.dp_inc = 2'b01; mstep(c, rw());
          c = dflt(); c.reg_write = 1; c.tr_write = 1; step(c);
        end
        8'h21: begin c = dflt(); c.dp_inc = 2'b10; c.tr_write = 1; step(c); end
        8'h24: begin c = dflt(); c.tr_write = 1; c.reg_write = 1; step(c); end
        8'h25: begin
          c = dflt(); c.out_write = 1; c.tr_write = 1; c.tr_src = 3'b100;
          c.dp_inc = 2'b10; step(c);
        end
        8'h31: begin
          c = dflt(); c.pc_write = 1; c.pc_src = 2'b10; c.tr_write = 1;
          c.dp_inc = 2'b10; step(c);
        end
        8'h22, 8'h23, 8'h80, 8'h81, 8'h26: begin
          c = dflt(); c.dp_inc = 2'b01; c.b_write = 0; step(c);
          c = dflt(); c.reg_write = 1;
          if (op != 8'h22) c.tr_write = 1;
          c.tr_src = (op == 8'h80) ? 3'b011 : (op == 8'h81) ? 3'b010 :
                     (op == 8'h26) ? 3'b101 : 3'b000;
          step(c);
        end
        8'h8A, 8'h8B, 8'h8C: begin
          c = dflt(); c.b_src = 3'b011; step(c);
          c = dflt(); c.tr_src = 3'b001; c.tr_write = 1; c.alu_src = 1;
          c.alu_op = op[3:0]; step(c);
        end
        8'h27: begin step(dflt()); m_ie = 1; end
        8'h28: begin step(dflt()); m_ie = 0; end
        default: ;
      endcase
    end
  endtask

  task automatic run_instr(input logic [7:0] op);
    fetch_decode(op);
    exec(op);
  endtask

  task automatic halt_cycle();
    ctl_t c;
    c = dflt(); c.halted = 1; step(c);
  endtask

  // stimulus
  initial begin
    ctl_t c;
    logic [7:0] pool[22] = '{8'h01, 8'h0F, 8'h11, 8'h12, 8'h13, 8'h14, 8'h21, 8'h22,
                             8'h23, 8'h24, 8'h25, 8'h26, 8'h27, 8'h28, 8'h31, 8'h80,
                             8'h81, 8'h8A, 8'h8C, 8'hC3, 8'hD5, 8'hF0};
    logic [7:0] op;
    reset = 1; irq = 0; opcode = 8'h00; mem_ready = 0;
    m_ie = 0; m_ill = 0; g_wmax = 0;
    @(posedge clk);
    #1;
    reset_tail(1'b1);

    // reset held two cycles starting in LD2
    fetch_decode(8'h11);
    c = dflt(); c.mem_req = 1; c.mem_addr = 2'b11; c.b_src = 3'b001; mstep(c, 0);
    c = dflt(); c.tr_write = 1; cyc(c, 1'b1, 1'b1);
    reset_tail(1'b1);

    run_instr(8'h01);

    // LD1 stretched by three wait cycles
    fetch_decode(8'h11);
    c = dflt(); c.mem_req = 1; c.mem_addr = 2'b11; c.b_src = 3'b001; mstep(c, 3);
    c = dflt(); c.tr_write = 1; step(c);

    // EI, then interrupt entry; a second request is ignored afterwards
    run_instr(8'h27);
    irq = 1;
    run_instr(8'h01);
    run_instr(8'h01);
    irq = 0;

    // HALT with interrupts disabled, left only by reset
    fetch_decode(8'h2F);
    irq = 1;
    repeat (20) halt_cycle();
    c = dflt(); c.halted = 1; cyc(c, 1'b1, 1'b1);
    reset_tail(1'b0);
    irq = 0;

    // HALT with interrupts enabled, woken by irq
    run_instr(8'h27);
    fetch_decode(8'h2F);
    repeat (3) halt_cycle();
    irq = 1;
    halt_cycle();
    irq_tail();
    irq = 0;
    run_instr(8'h01);

    // illegal opcode is sticky until reset
    run_instr(8'h55);
    run_instr(8'h01);
    run_instr(8'h24);
    c = dflt(); c.mem_req = 1; c.ir_write = 1; c.pc_write = 1; cyc(c, 1'b1, 1'b1);
    reset_tail(1'b0);

    // randomized instruction stream with waits and interrupts
    for (int i = 0; i < 400; i++) begin
      g_wmax = ($urandom_range(0, 3) == 0) ? 3 : 0;
      irq = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 3) == 0) op = 8'($urandom_range(0, 255));
      else op = pool[$urandom_range(0, 21)];
      if (op == 8'h2F) op = 8'h01;
      run_instr(op);
    end
    irq = 0;

    @(negedge clk);
    #1;
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL queue_drain: %0d left, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
